// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M/RV64M multiply/divide unit for the EX stage.
//                Radix-2 shift-add multiplier and restoring divider share one
//                XLEN-cycle sequencer; stalls the pipeline while busy and
//                delivers the result with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_0,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ready,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  c_ONES = {XLEN{1'b1}};

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_f3;
    logic               r_neg;
    logic [XLEN-1:0]    r_opb;
    logic [2*XLEN-1:0]  r_acc;
    logic               r_done;
    logic [XLEN-1:0]    r_result;

    logic               w_start;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_sa;
    logic               w_sb;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_neg;
    logic               w_div0;
    logic               w_ovf;
    logic [XLEN-1:0]    w_special_val;
    logic [XLEN:0]      w_top;
    logic [XLEN:0]      w_diff;
    logic [XLEN:0]      w_sum;
    logic [2*XLEN-1:0]  w_step;
    logic [2*XLEN-1:0]  w_prod_fix;
    logic [XLEN-1:0]    w_mul_res;
    logic [XLEN-1:0]    w_div_raw;
    logic [XLEN-1:0]    w_div_res;
    logic [XLEN-1:0]    w_final;

    assign w_start = valid_in & (alu_op == 2'b10) & funct7_0 & (r_state == S_IDLE);
    assign ready   = (r_state == S_IDLE);
    assign stall   = w_start | (r_state == S_BUSY);
    assign done    = r_done;
    assign result  = r_result;

    // Operand decode at accept: signedness, magnitudes, result sign, special cases
    always_comb begin
        w_a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) |
                     (funct3 == 3'b100) | (funct3 == 3'b110);
        w_b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
        w_sa       = a[XLEN-1] & w_a_signed;
        w_sb       = b[XLEN-1] & w_b_signed;
        w_mag_a    = w_sa ? -a : a;
        w_mag_b    = w_sb ? -b : b;
        // REM takes the dividend sign; every other signed op takes the XOR
        w_neg      = (funct3[2] & funct3[1]) ? w_sa : (w_sa ^ w_sb);
        w_div0     = funct3[2] & (b == '0);
        w_ovf      = funct3[2] & ~funct3[0] & (a == c_MIN) & (b == c_ONES);
        if (w_div0)
            w_special_val = funct3[1] ? a : c_ONES;
        else
            w_special_val = funct3[1] ? '0 : c_MIN;
    end

    // One iteration of shift-add multiply or restoring divide on the accumulator
    always_comb begin
        w_top  = r_acc[2*XLEN-1:XLEN-1];
        w_diff = w_top - {1'b0, r_opb};
        w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        if (r_f3[2]) begin
            if (w_diff[XLEN])
                w_step = {r_acc[2*XLEN-2:0], 1'b0};
            else
                w_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_step = {w_sum, r_acc[XLEN-1:1]};
        end
    end

    // Sign correction and result selection from the final iteration
    always_comb begin
        w_prod_fix = r_neg ? -w_step : w_step;
        w_mul_res  = (r_f3[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0]
                                          : w_prod_fix[2*XLEN-1:XLEN];
        w_div_raw  = r_f3[1] ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];
        w_div_res  = r_neg ? -w_div_raw : w_div_raw;
        w_final    = r_f3[2] ? w_div_res : w_mul_res;
    end

    // Sequencer: IDLE -> BUSY (XLEN iterations) -> DONE, result registered on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_f3  <= funct3;
                        r_neg <= w_neg;
                        r_opb <= w_mag_b;
                        r_acc <= {{XLEN{1'b0}}, w_mag_a};
                        r_cnt <= '0;
                        if (w_div0 | w_ovf) begin
                            r_result <= w_special_val;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Scoreboard bench for muldiv_unit (XLEN=32 and XLEN=64).
//                Expected results come from a wide-integer arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    typedef struct {
        logic [63:0] val;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_0;
    logic        flush;
    logic        valid32;
    logic        valid64;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        ready32, stall32, done32;
    logic        ready64, stall64, done64;
    logic [31:0] result32;
    logic [63:0] result64;

    int          cyc;
    int          n_pass;
    int          n_total;
    exp_t        q32[$];
    exp_t        q64[$];
    logic [63:0] last32;

    muldiv_unit #(.XLEN(32)) u_dut32 (
        .clk      (clk),
        .rst      (rst),
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7_0 (funct7_0),
        .valid_in (valid32),
        .flush    (flush),
        .a        (a_in[31:0]),
        .b        (b_in[31:0]),
        .ready    (ready32),
        .stall    (stall32),
        .done     (done32),
        .result   (result32)
    );

    muldiv_unit #(.XLEN(64)) u_dut64 (
        .clk      (clk),
        .rst      (rst),
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7_0 (funct7_0),
        .valid_in (valid64),
        .flush    (flush),
        .a        (a_in),
        .b        (b_in),
        .ready    (ready64),
        .stall    (stall64),
        .done     (done64),
        .result   (result64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number: constant within a cycle, steps on each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    endtask

    // Reference: RISC-V M semantics with 128-bit integer arithmetic
    function automatic logic [63:0] ref_op(input int xl, input logic [2:0] f3,
                                           input logic [63:0] av_i, input logic [63:0] bv_i);
        logic signed [127:0] sa, sb, ua, ub, p, t;
        logic [63:0] mask, minv, av, bv, r;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        minv = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        av = av_i & mask;
        bv = bv_i & mask;
        ua = {64'd0, av};
        ub = {64'd0, bv};
        sa = ((av & minv) != 0) ? ua - (128'sd1 << xl) : ua;
        sb = ((bv & minv) != 0) ? ub - (128'sd1 << xl) : ub;
        r  = '0;
        case (f3)
            3'b000: begin p = ua * ub; r = p[63:0]; end
            3'b001: begin p = sa * sb; t = p >>> xl; r = t[63:0]; end
            3'b010: begin p = sa * ub; t = p >>> xl; r = t[63:0]; end
            3'b011: begin p = ua * ub; t = p >>> xl; r = t[63:0]; end
            3'b100: begin
                if (bv == 0) r = mask;
                else if (av == minv && bv == mask) r = minv;
                else begin p = sa / sb; r = p[63:0]; end
            end
            3'b101: begin
                if (bv == 0) r = mask;
                else begin p = ua / ub; r = p[63:0]; end
            end
            3'b110: begin
                if (bv == 0) r = av;
                else if (av == minv && bv == mask) r = '0;
                else begin p = sa % sb; r = p[63:0]; end
            end
            default: begin
                if (bv == 0) r = av;
                else begin p = ua % ub; r = p[63:0]; end
            end
        endcase
        return r & mask;
    endfunction

    function automatic bit is_special(input int xl, input logic [2:0] f3,
                                      input logic [63:0] av_i, input logic [63:0] bv_i);
        logic [63:0] mask, minv, av, bv;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        minv = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        av = av_i & mask;
        bv = bv_i & mask;
        return f3[2] && ((bv == 0) || (!f3[0] && av == minv && bv == mask));
    endfunction

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
            2:       v = '1;
            3:       v = 64'($urandom_range(0, 9));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Scoreboard monitors: compare every done pulse with the oldest expectation
    always @(negedge clk) begin : mon32
        exp_t e;
        if (!rst && done32 === 1'b1) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                last32 = e.val;
                chk("result32", {32'd0, result32}, e.val);
                chk("latency32", 64'(cyc), 64'(e.due));
                chk("stall_in_done32", {63'd0, stall32}, 64'd0);
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (!rst && done64 === 1'b1) begin
            if (q64.size() == 0) begin
                chk("unexpected_done64", 64'd1, 64'd0);
            end else begin
                e = q64.pop_front();
                chk("result64", result64, e.val);
                chk("latency64", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Waits for ready, presents one M-op for one cycle, optionally records the expectation
    task automatic issue(input bit w64, input logic [2:0] f3, input logic [63:0] av,
                         input logic [63:0] bv, input bit track, output int acc_cyc);
        int   n;
        int   xl;
        exp_t e;
        xl = w64 ? 64 : 32;
        n  = 0;
        while (((w64 ? ready64 : ready32) !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        if (n >= 300) begin
            n_total++;
            $display("FAIL ready_timeout: unit not ready after %0d cycles (w64=%0d)", n, w64);
            return;
        end
        funct3   = f3;
        alu_op   = 2'b10;
        funct7_0 = 1'b1;
        a_in     = av;
        b_in     = bv;
        if (w64) valid64 = 1'b1;
        else     valid32 = 1'b1;
        #1;
        if (w64) chk("stall_start64", {63'd0, stall64}, 64'd1);
        else     chk("stall_start32", {63'd0, stall32}, 64'd1);
        acc_cyc = cyc;
        if (track) begin
            e.val = ref_op(xl, f3, av, bv);
            e.due = cyc + (is_special(xl, f3, av, bv) ? 1 : xl + 1);
            if (w64) q64.push_back(e);
            else     q32.push_back(e);
        end
        @(negedge clk);
        valid32 = 1'b0;
        valid64 = 1'b0;
        a_in    = {$urandom, $urandom};
        b_in    = {$urandom, $urandom};
        funct3  = 3'($urandom);
    endtask

    initial begin
        int c0;
        int n;
        cyc      = 0;
        n_pass   = 0;
        n_total  = 0;
        last32   = '0;
        rst      = 1'b1;
        alu_op   = 2'b00;
        funct3   = 3'b000;
        funct7_0 = 1'b0;
        flush    = 1'b0;
        valid32  = 1'b0;
        valid64  = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready32",  {63'd0, ready32}, 64'd1);
        chk("rst_stall32",  {63'd0, stall32}, 64'd0);
        chk("rst_done32",   {63'd0, done32},  64'd0);
        chk("rst_result32", {32'd0, result32}, 64'd0);
        chk("rst_ready64",  {63'd0, ready64}, 64'd1);
        chk("rst_result64", result64, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MUL 7 x -3 with per-cycle stall check through the busy window
        issue(1'b0, 3'b000, 64'd7, 64'hFFFF_FFFD, 1'b1, c0);
        for (int k = 1; k <= 32; k++) begin
            chk("stall_busy32", {63'd0, stall32}, 64'd1);
            @(negedge clk);
        end
        @(negedge clk);
        chk("ready_after_done32", {63'd0, ready32}, 64'd1);

        // Directed values
        issue(1'b0, 3'b001, 64'h8000_0000, 64'h8000_0000, 1'b1, c0);
        issue(1'b0, 3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, c0);
        issue(1'b0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, c0);
        issue(1'b0, 3'b100, 64'hFFFF_FFF9, 64'd2, 1'b1, c0);
        issue(1'b0, 3'b110, 64'hFFFF_FFF9, 64'd2, 1'b1, c0);
        issue(1'b0, 3'b101, 64'd100, 64'd7, 1'b1, c0);
        issue(1'b0, 3'b111, 64'd100, 64'd7, 1'b1, c0);
        issue(1'b0, 3'b101, 64'd5, 64'd0, 1'b1, c0);
        issue(1'b0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, c0);
        issue(1'b0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, c0);
        issue(1'b0, 3'b110, 64'd12345, 64'd0, 1'b1, c0);

        // Flush mid-divide: back to IDLE, no done, result held
        issue(1'b0, 3'b100, 64'd1000, 64'd3, 1'b0, c0);
        while (cyc < c0 + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_stall32",  {63'd0, stall32}, 64'd0);
        chk("flush_ready32",  {63'd0, ready32}, 64'd1);
        chk("flush_result32", {32'd0, result32}, last32);
        repeat (40) @(negedge clk);

        // Reset mid-divide: result cleared, ready
        issue(1'b0, 3'b100, 64'd1000, 64'd3, 1'b0, c0);
        while (cyc < c0 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_result32", {32'd0, result32}, 64'd0);
        chk("midrst_ready32",  {63'd0, ready32},  64'd1);
        chk("midrst_done32",   {63'd0, done32},   64'd0);
        last32 = '0;
        repeat (40) @(negedge clk);

        // Non-M ops are ignored
        valid32 = 1'b1; alu_op = 2'b10; funct7_0 = 1'b0; funct3 = 3'b000;
        #1;
        chk("add_stall32", {63'd0, stall32}, 64'd0);
        @(negedge clk);
        chk("add_ready32", {63'd0, ready32}, 64'd1);
        alu_op = 2'b00; funct7_0 = 1'b1;
        #1;
        chk("aluop00_stall32", {63'd0, stall32}, 64'd0);
        @(negedge clk);
        chk("aluop00_ready32", {63'd0, ready32}, 64'd1);

        // Flush together with start: nothing accepted
        alu_op = 2'b10; funct7_0 = 1'b1; flush = 1'b1; a_in = 64'd9; b_in = 64'd3; funct3 = 3'b101;
        @(negedge clk);
        valid32 = 1'b0; flush = 1'b0;
        chk("flush_start_ready32", {63'd0, ready32}, 64'd1);
        repeat (40) @(negedge clk);

        // Randomized 32-bit ops
        for (int i = 0; i < 40; i++)
            issue(1'b0, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1'b1, c0);

        // 64-bit unit
        issue(1'b1, 3'b000, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b1, c0);
        for (int i = 0; i < 20; i++)
            issue(1'b1, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1'b1, c0);

        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain64", 64'(q64.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised successor to the ALU-op decoder: decodes R-format ops with funct7=0000001 (RV32M/RV64M) and executes them iteratively.
- Radix-2 shift-add multiplier and restoring divider share one XLEN-cycle sequencer.
- Sits beside the ALU in EX.
- Raises `stall` to freeze the pipeline while busy and delivers the result with a one-cycle `done` pulse.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- alu_op  in  2  main-control ALU op; only 2'b10 (R-format) is considered.
- funct3  in  3  instruction[14:12]; selects the M op.
- funct7_0  in  1  instruction[25]; 1 = M-extension op.
- valid_in  in  1  EX stage holds a valid instruction.
- flush  in  1  synchronous abort (branch/exception); highest priority after rst.
- a  in  XLEN  rs1 value.
- b  in  XLEN  rs2 value.
- ready  out  1  1 in IDLE only.
- stall  out  1  hold pipeline: combinational start OR state!=IDLE and state!=DONE.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  registered result, held until the next accept.

Behaviour:
- Reset: clk and rst are the only clock/reset. Reset is synchronous, active-high, one clock domain.
  - On rst: state=IDLE, ready=1, done=0, stall=0, result=0, counter=0, internal regs=0.
  - Applies mid-operation: the op is lost and no done is issued.
- start = valid_in & (alu_op==2'b10) & funct7_0 & ready. Accepted on the rising edge where start=1.
- funct3 map:
  - 000 MUL (low XLEN)
  - 001 MULH (ss high)
  - 010 MULHSU (s×u high)
  - 011 MULHU (uu high)
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- States:
  - IDLE: on start, latch funct3, magnitudes |a|,|b| (signed ops only), result sign, clear counter.
    - If a special case applies -> DONE; else -> BUSY.
  - BUSY: one iteration per cycle; counter increments. On counter==XLEN-1 -> DONE.
  - DONE: sign-correct and write `result`, assert done=1 for exactly this cycle, -> IDLE.
- Latency:
  - Normal op: done asserted in the cycle beginning XLEN+1 edges after the accepting edge (33 for XLEN=32).
  - Special case: done in the cycle after the accepting edge.
  - Back-to-back: a new start is accepted in IDLE only, so throughput is one op per XLEN+2 cycles.
- Multiply: 2·XLEN product register; add multiplicand when multiplier LSB=1, shift right. Signed results use two's-complement negation of the full 2·XLEN product.
- Divide: restoring; remainder/quotient shift register of 2·XLEN.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Special cases (RISC-V defined, no trap):
  - b==0: quotient = all ones; remainder = a.
  - Signed DIV/REM with a=MIN and b=-1: quotient = MIN, remainder = 0.
- stall: 1 from the accepting cycle (combinational) through the cycle before DONE. 0 in DONE so the pipeline advances with `result`.
- flush: any state -> IDLE next edge; done stays 0; result unchanged. If flush and start occur together, flush wins and nothing is accepted.
- Inputs a/b/funct3 may change after accept; the unit uses only latched copies.
- Non-M ops (funct7_0=0 or alu_op!=10) are ignored entirely: no stall, no state change.

Test Plan:
- MUL, XLEN=32, a=7, b=0xFFFFFFFD -> stall 1 for cycles 0..32; done=1 at cycle 33; result=0xFFFFFFEB; then ready=1.
- MULH a=b=0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=5, b=0 -> done at cycle 1, result=0xFFFFFFFF. REM a=0x80000000, b=0xFFFFFFFF -> done at cycle 1, result=0.
- Start DIV, assert flush at cycle 10 -> IDLE at cycle 11, stall=0, done never asserted, result keeps its old value. Repeat with rst at cycle 10 -> result=0, ready=1.
- valid_in=1, alu_op=10, funct7_0=0 (plain ADD) -> stall=0, state stays IDLE. Repeat with XLEN=64: MUL 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE00000001, done at cycle 65.
